// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Provides RV64 load/store funct3 encodings, the access-size enum, the
// responder FSM state type and an alignment helper.
package dmem_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_LILL = 3'b111;  // no load uses this encoding

  // Store funct3 encodings (anything with bit 2 set is illegal)
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_WAIT = 2'b01, ST_RESP = 2'b10} state_e;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic misaligned(input size_e sz, input logic [2:0] lo);
    case (sz)
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      SZ_D:    return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data-memory responder (purely combinational).
//   funct3_i : access funct3 (size in [1:0], unsigned-load in [2])
//   lane_i   : byte offset of the access within the 64-bit word
//   wdata_i  : right-justified store data
//   rword_i  : current RAM word
//   wword_o  : RAM word with the store bytes merged in
//   rdata_o  : load result, lane-extracted and sign/zero extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rword_i,
  output logic [63:0] wword_o,
  output logic [63:0] rdata_o
);
  size_e       sz;
  logic [7:0]  be_base, be;
  logic [63:0] wsh, rsh;
  logic        sx;

  assign sz  = size_e'(funct3_i[1:0]);
  assign wsh = wdata_i << {lane_i, 3'b000};
  assign rsh = rword_i >> {lane_i, 3'b000};
  assign be  = be_base << lane_i;
  assign sx  = ~funct3_i[2];

  always_comb begin
    case (sz)
      SZ_B:    be_base = 8'h01;
      SZ_H:    be_base = 8'h03;
      SZ_W:    be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
  end

  always_comb begin
    wword_o = rword_i;
    for (int i = 0; i < 8; i++)
      if (be[i]) wword_o[i*8 +: 8] = wsh[i*8 +: 8];
  end

  always_comb begin
    case (sz)
      SZ_B:    rdata_o = {{56{sx & rsh[7]}},  rsh[7:0]};
      SZ_H:    rdata_o = {{48{sx & rsh[15]}}, rsh[15:0]};
      SZ_W:    rdata_o = {{32{sx & rsh[31]}}, rsh[31:0]};
      default: rdata_o = rsh;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: 64-bit byte-addressed RAM with
// sized RV64 loads/stores, fault detection and a fixed-latency handshake.
//   CLK, RESET        : clock, synchronous active-high reset
//   DMEM_REQ/WE/FUNCT3/ADDR/WDATA : request (sampled only when idle)
//   DMEM_READY        : one-cycle completion pulse
//   DMEM_BUSY         : request accepted and still waiting
//   DMEM_RDATA        : load result (0 for stores and faults)
//   DMEM_LAM/LAF/SAM/SAF : fault flags, valid with READY
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DMEM_REQ,
  input  logic        DMEM_WE,
  input  logic [2:0]  DMEM_FUNCT3,
  input  logic [63:0] DMEM_ADDR,
  input  logic [63:0] DMEM_WDATA,
  output logic        DMEM_READY,
  output logic        DMEM_BUSY,
  output logic [63:0] DMEM_RDATA,
  output logic        DMEM_LAM,
  output logic        DMEM_LAF,
  output logic        DMEM_SAM,
  output logic        DMEM_SAF
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [63:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [3:0]    flags_q, flags_d;  // {LAM, LAF, SAM, SAF}
  logic          wr_en;

  logic [63:0]   mem_q [DEPTH_WORDS];

  // In IDLE the live request is classified (faults respond next cycle);
  // afterwards only the latched copy is used.
  logic          idle, we_c, mis_c, ill_c, oor_c, fault_c, go_resp;
  logic [2:0]    f3_c;
  logic [63:0]   addr_c, wdata_c, rword_c, wword_c, load_c;
  logic [60:0]   woff_c;
  logic [AW-1:0] idx_c;

  assign idle    = (state_q == ST_IDLE);
  assign we_c    = idle ? DMEM_WE     : we_q;
  assign f3_c    = idle ? DMEM_FUNCT3 : f3_q;
  assign addr_c  = idle ? DMEM_ADDR   : addr_q;
  assign wdata_c = idle ? DMEM_WDATA  : wdata_q;

  // Word offset from the base, with 64-bit wrap for addresses below BASE_ADDR.
  assign woff_c  = 61'((addr_c - BASE_ADDR) >> 3);
  assign idx_c   = woff_c[AW-1:0];
  assign oor_c   = |(woff_c >> AW);
  assign mis_c   = misaligned(size_e'(f3_c[1:0]), addr_c[2:0]);
  assign ill_c   = we_c ? f3_c[2] : (f3_c == F3_LILL);
  assign fault_c = mis_c | ill_c | oor_c;
  assign rword_c = mem_q[idx_c];

  dmem_lane_align u_lane (
    .funct3_i (f3_c),
    .lane_i   (addr_c[2:0]),
    .wdata_i  (wdata_c),
    .rword_i  (rword_c),
    .wword_o  (wword_c),
    .rdata_o  (load_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    rdata_d = '0;
    flags_d = '0;
    wr_en   = 1'b0;
    go_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (DMEM_REQ) begin
          we_d    = DMEM_WE;
          f3_d    = DMEM_FUNCT3;
          addr_d  = DMEM_ADDR;
          wdata_d = DMEM_WDATA;
          if (fault_c || LATENCY == 1) begin
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) go_resp = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Response values are registered on the edge entering RESP.
    if (go_resp) begin
      state_d = ST_RESP;
      ready_d = 1'b1;
      if (fault_c) begin
        // Misalignment wins over access fault: exactly one flag per fault.
        flags_d = {~we_c & mis_c, ~we_c & ~mis_c, we_c & mis_c, we_c & ~mis_c};
      end else if (we_c) begin
        wr_en = 1'b1;
      end else begin
        rdata_d = load_c;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      flags_q <= flags_d;
    end
  end

  // RAM is not reset; a reset on the commit edge drops the store.
  always_ff @(posedge CLK) begin
    if (wr_en && !RESET) mem_q[idx_c] <= wword_c;
  end

  assign DMEM_READY = ready_q;
  assign DMEM_BUSY  = (state_q == ST_WAIT);
  assign DMEM_RDATA = rdata_q;
  assign {DMEM_LAM, DMEM_LAF, DMEM_SAM, DMEM_SAF} = flags_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed checks of data_mem_responder against a byte-array
// reference model of the memory.
module tb_data_mem_responder;
  localparam int          DEPTH = 512;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        DMEM_REQ, DMEM_WE;
  logic [2:0]  DMEM_FUNCT3;
  logic [63:0] DMEM_ADDR, DMEM_WDATA;
  logic        DMEM_READY, DMEM_BUSY;
  logic [63:0] DMEM_RDATA;
  logic        DMEM_LAM, DMEM_LAF, DMEM_SAM, DMEM_SAF;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET(RESET), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_FUNCT3(DMEM_FUNCT3), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_READY(DMEM_READY), .DMEM_BUSY(DMEM_BUSY), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_LAM(DMEM_LAM), .DMEM_LAF(DMEM_LAF), .DMEM_SAM(DMEM_SAM), .DMEM_SAF(DMEM_SAF)
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passed = 0;

  // Reference memory, one entry per byte.
  logic [7:0] mb [DEPTH*8];

  // Expected outcome of one request; updates the model memory for good stores.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, output logic [63:0] er,
                           output logic [3:0] ef, output int el);
    int n;
    logic mis, bad;
    logic [63:0] off;
    n   = 1 << f3[1:0];
    mis = (a % 64'(n)) != 0;
    off = a - BASE;
    bad = (we ? f3[2] : (f3 == 3'b111)) || ((off / 8) >= 64'(DEPTH));
    er  = '0;
    ef  = '0;
    if (mis)      ef = we ? 4'b0010 : 4'b1000;
    else if (bad) ef = we ? 4'b0001 : 4'b0100;
    el = (ef != 0) ? 1 : LAT;
    if (ef == 0) begin
      for (int i = 0; i < n; i++)
        if (we) mb[int'(off) + i] = wd[8*i +: 8];
        else    er = er | (64'(mb[int'(off) + i]) << (8*i));
      if (!we && !f3[2] && n < 8 && er[8*n-1]) er = er | (~64'd0 << (8*n));
    end
  endtask

  // Drives one request and observes its completion. lat = -1 on timeout.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output int lat, output logic [63:0] rd,
                        output logic [3:0] fl, output int busy_bad, output int post_bad);
    @(negedge CLK);
    DMEM_REQ = 1'b1; DMEM_WE = we; DMEM_FUNCT3 = f3; DMEM_ADDR = a; DMEM_WDATA = wd;
    @(posedge CLK);
    lat = -1; rd = '0; fl = '0; busy_bad = 0; post_bad = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge CLK);
      if (DMEM_READY === 1'b1) begin
        lat = k; rd = DMEM_RDATA;
        fl  = {DMEM_LAM, DMEM_LAF, DMEM_SAM, DMEM_SAF};
        break;
      end
      if (DMEM_BUSY !== 1'b1) busy_bad++;
      // Fields were latched at acceptance; changing them now must not matter.
      DMEM_WE = ~we; DMEM_FUNCT3 = 3'($urandom); DMEM_ADDR = {$urandom, $urandom};
      DMEM_WDATA = {$urandom, $urandom};
    end
    DMEM_REQ = 1'b0;
    @(negedge CLK);
    if (DMEM_READY !== 1'b0 || DMEM_BUSY !== 1'b0 || DMEM_RDATA !== 64'h0 ||
        {DMEM_LAM, DMEM_LAF, DMEM_SAM, DMEM_SAF} !== 4'h0) post_bad++;
  endtask

  task automatic test_reset();
    RESET = 1'b1; DMEM_REQ = 1'b0; DMEM_WE = 1'b0; DMEM_FUNCT3 = '0;
    DMEM_ADDR = '0; DMEM_WDATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({DMEM_READY, DMEM_BUSY, DMEM_LAM, DMEM_LAF, DMEM_SAM, DMEM_SAF, DMEM_RDATA} !== 70'h0)
      $display("FAIL reset_outputs: got ready=%b busy=%b flags=%b rdata=%h, want all 0",
               DMEM_READY, DMEM_BUSY, {DMEM_LAM, DMEM_LAF, DMEM_SAM, DMEM_SAF}, DMEM_RDATA);
    else passed++;
    RESET = 1'b0;
    @(negedge CLK);
    total++;
    if ({DMEM_READY, DMEM_BUSY} !== 2'b00)
      $display("FAIL post_reset_idle: got ready=%b busy=%b, want 0 0", DMEM_READY, DMEM_BUSY);
    else passed++;
  endtask

  task automatic init_mem();
    logic [63:0] er; logic [3:0] ef, fl; int el, lat, bb, pb, bad;
    logic [63:0] rd, a;
    bad = 0;
    for (int w = 0; w < 18; w++) begin
      a = (w < 16) ? 64'(w*8) : 64'((DEPTH - 18 + w) * 8);
      model_req(1'b1, 3'b011, a, {$urandom, $urandom}, er, ef, el);
      do_req(1'b1, 3'b011, a, {mb[int'(a)+7], mb[int'(a)+6], mb[int'(a)+5], mb[int'(a)+4],
                               mb[int'(a)+3], mb[int'(a)+2], mb[int'(a)+1], mb[int'(a)]},
             lat, rd, fl, bb, pb);
      if (lat != el || fl != ef) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL init_stores: got %0d bad completions, want 0", bad);
    else passed++;
  endtask

  task automatic test_store_load();
    logic [63:0] er, rd; logic [3:0] ef, fl; int el, lat, bb, pb;
    model_req(1'b1, 3'b011, 64'h10, 64'h1122334455667788, er, ef, el);
    do_req(1'b1, 3'b011, 64'h10, 64'h1122334455667788, lat, rd, fl, bb, pb);
    total++;
    if (lat != LAT || fl !== 4'h0 || rd !== 64'h0)
      $display("FAIL sd_0x10: got lat=%0d flags=%b rdata=%h, want lat=%0d flags=0000 rdata=0", lat, fl, rd, LAT);
    else passed++;
    model_req(1'b0, 3'b011, 64'h10, 64'h0, er, ef, el);
    do_req(1'b0, 3'b011, 64'h10, 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (lat != LAT || fl !== 4'h0 || rd !== 64'h1122334455667788 || bb != 0 || pb != 0)
      $display("FAIL ld_0x10: got lat=%0d flags=%b rdata=%h busy_bad=%0d post_bad=%0d, want lat=%0d flags=0000 rdata=1122334455667788",
               lat, fl, rd, bb, pb, LAT);
    else passed++;
  endtask

  task automatic test_byte_merge();
    logic [63:0] er, rd; logic [3:0] ef, fl; int el, lat, bb, pb;
    model_req(1'b1, 3'b000, 64'h13, 64'hDEAD_BEEF_0000_00FF, er, ef, el);
    do_req(1'b1, 3'b000, 64'h13, 64'hDEAD_BEEF_0000_00FF, lat, rd, fl, bb, pb);
    total++;
    if (lat != LAT || fl !== 4'h0)
      $display("FAIL sb_0x13: got lat=%0d flags=%b, want lat=%0d flags=0000", lat, fl, LAT);
    else passed++;
    do_req(1'b0, 3'b000, 64'h13, 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF || fl !== 4'h0)
      $display("FAIL lb_0x13: got rdata=%h flags=%b, want ffffffffffffffff 0000", rd, fl);
    else passed++;
    do_req(1'b0, 3'b100, 64'h13, 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (rd !== 64'hFF || fl !== 4'h0)
      $display("FAIL lbu_0x13: got rdata=%h flags=%b, want 00000000000000ff 0000", rd, fl);
    else passed++;
    do_req(1'b0, 3'b011, 64'h10, 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (rd !== 64'h11223344FF667788)
      $display("FAIL ld_merged: got rdata=%h, want 11223344ff667788", rd);
    else passed++;
  endtask

  task automatic test_faults();
    logic [63:0] er, rd; logic [3:0] ef, fl; int el, lat, bb, pb;
    do_req(1'b0, 3'b010, 64'h12, 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (lat != 1 || fl !== 4'b1000 || rd !== 64'h0)
      $display("FAIL lw_misaligned: got lat=%0d flags=%b rdata=%h, want lat=1 flags=1000 rdata=0", lat, fl, rd);
    else passed++;
    do_req(1'b1, 3'b001, 64'h21, 64'hA5A5, lat, rd, fl, bb, pb);
    total++;
    if (lat != 1 || fl !== 4'b0010)
      $display("FAIL sh_misaligned: got lat=%0d flags=%b, want lat=1 flags=0010", lat, fl);
    else passed++;
    model_req(1'b0, 3'b011, 64'h20, 64'h0, er, ef, el);
    do_req(1'b0, 3'b011, 64'h20, 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (rd !== er) $display("FAIL sam_no_write: got rdata=%h, want %h", rd, er);
    else passed++;
    do_req(1'b0, 3'b011, BASE + 64'(DEPTH*8), 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (lat != 1 || fl !== 4'b0100 || rd !== 64'h0)
      $display("FAIL ld_out_of_range: got lat=%0d flags=%b rdata=%h, want lat=1 flags=0100 rdata=0", lat, fl, rd);
    else passed++;
    do_req(1'b1, 3'b100, 64'h40, 64'h1234, lat, rd, fl, bb, pb);
    total++;
    if (lat != 1 || fl !== 4'b0001)
      $display("FAIL store_illegal_f3: got lat=%0d flags=%b, want lat=1 flags=0001", lat, fl);
    else passed++;
    do_req(1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (lat != 1 || fl !== 4'b1000)
      $display("FAIL mis_over_range: got lat=%0d flags=%b, want lat=1 flags=1000", lat, fl);
    else passed++;
  endtask

  task automatic test_reset_abort();
    logic [63:0] er, rd; logic [3:0] ef, fl; int el, lat, bb, pb;
    model_req(1'b0, 3'b011, 64'h30, 64'h0, er, ef, el);  // prior contents
    @(negedge CLK);
    DMEM_REQ = 1'b1; DMEM_WE = 1'b1; DMEM_FUNCT3 = 3'b011; DMEM_ADDR = 64'h30;
    DMEM_WDATA = ~er;
    @(posedge CLK);
    @(negedge CLK);
    total++;
    if (DMEM_BUSY !== 1'b1) $display("FAIL abort_wait_busy: got busy=%b, want 1", DMEM_BUSY);
    else passed++;
    RESET = 1'b1; DMEM_REQ = 1'b0;
    @(negedge CLK);
    total++;
    if (DMEM_READY !== 1'b0 || DMEM_BUSY !== 1'b0)
      $display("FAIL abort_no_ready: got ready=%b busy=%b, want 0 0", DMEM_READY, DMEM_BUSY);
    else passed++;
    RESET = 1'b0;
    @(negedge CLK);
    total++;
    if (DMEM_READY !== 1'b0) $display("FAIL abort_late_ready: got ready=%b, want 0", DMEM_READY);
    else passed++;
    do_req(1'b0, 3'b011, 64'h30, 64'h0, lat, rd, fl, bb, pb);
    total++;
    if (rd !== er || lat != LAT) $display("FAIL abort_ram_kept: got rdata=%h lat=%0d, want %h lat=%0d", rd, lat, er, LAT);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic        w [3];
    logic [2:0]  f [3];
    logic [63:0] ad [3], wv [3], er [3], grd [3];
    logic [3:0]  ef [3], gfl [3];
    int el [3], rc [3];
    int nr, busy_n;
    w[0] = 1'b1; f[0] = 3'b011; ad[0] = 64'h48; wv[0] = {$urandom, $urandom};
    w[1] = 1'b0; f[1] = 3'b011; ad[1] = 64'h48; wv[1] = 64'h0;
    w[2] = 1'b0; f[2] = 3'b110; ad[2] = 64'h4C; wv[2] = 64'h0;
    for (int i = 0; i < 3; i++) begin
      model_req(w[i], f[i], ad[i], wv[i], er[i], ef[i], el[i]);
      rc[i] = -1; grd[i] = 'x; gfl[i] = 'x;
    end
    nr = 0; busy_n = 0;
    @(negedge CLK);
    DMEM_REQ = 1'b1; DMEM_WE = w[0]; DMEM_FUNCT3 = f[0]; DMEM_ADDR = ad[0]; DMEM_WDATA = wv[0];
    for (int c = 1; c <= 4*(LAT+1) + 4 && nr < 3; c++) begin
      @(negedge CLK);
      if (DMEM_BUSY === 1'b1) busy_n++;
      if (DMEM_READY === 1'b1) begin
        rc[nr] = c; grd[nr] = DMEM_RDATA;
        gfl[nr] = {DMEM_LAM, DMEM_LAF, DMEM_SAM, DMEM_SAF};
        nr++;
        if (nr < 3) begin
          DMEM_WE = w[nr]; DMEM_FUNCT3 = f[nr]; DMEM_ADDR = ad[nr]; DMEM_WDATA = wv[nr];
        end else DMEM_REQ = 1'b0;
      end
    end
    DMEM_REQ = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rc[i] != LAT + i*(LAT+1) || grd[i] !== er[i] || gfl[i] !== ef[i])
        $display("FAIL b2b_req%0d: got cycle=%0d rdata=%h flags=%b, want cycle=%0d rdata=%h flags=%b",
                 i, rc[i], grd[i], gfl[i], LAT + i*(LAT+1), er[i], ef[i]);
      else passed++;
    end
    total++;
    if (busy_n != 3*(LAT-1)) $display("FAIL b2b_busy: got %0d busy cycles, want %0d", busy_n, 3*(LAT-1));
    else passed++;
  endtask

  task automatic test_random();
    logic we; logic [2:0] f3; logic [63:0] a, wd, er, rd; logic [3:0] ef, fl;
    int el, lat, bb, pb;
    for (int t = 0; t < 150; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 64'(DEPTH*8 - 16) + 64'($urandom_range(0, 15));
        1:       a = 64'(DEPTH*8) + 64'($urandom_range(0, 255));
        2:       a = {$urandom | 32'h1, $urandom};
        default: a = 64'($urandom_range(0, 127));
      endcase
      if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      wd = {$urandom, $urandom};
      model_req(we, f3, a, wd, er, ef, el);
      do_req(we, f3, a, wd, lat, rd, fl, bb, pb);
      total++;
      if (lat != el || rd !== er || fl !== ef || bb != 0 || pb != 0)
        $display("FAIL rand%0d we=%b f3=%b addr=%h: got lat=%0d rdata=%h flags=%b busy_bad=%0d post_bad=%0d, want lat=%0d rdata=%h flags=%b",
                 t, we, f3, a, lat, rd, fl, bb, pb, el, er, ef);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_store_load();
    test_byte_merge();
    test_faults();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
